// File: rtl/tetris_pkg.sv
// Shared types and constants for the tetris playfield store.
package tetris_pkg;

    typedef enum logic [2:0] {
        F_IDLE,
        F_LOCK,
        F_SCAN,
        F_SHIFT,
        F_RISE,
        F_DONE
    } field_state_t;

    localparam int KIND_EMPTY   = 0;
    localparam int KIND_GARBAGE = 8;

endpackage

// File: rtl/tetris_field_if.sv
// Lock and garbage handshakes between piece control and the playfield.
interface tetris_field_if #(
    parameter int COLS   = 10,
    parameter int ROWS   = 20,
    parameter int KIND_W = 4
);
    logic                   lock_valid;
    logic                   lock_ready;
    logic [COLS*ROWS-1:0]   lock_mask;
    logic [KIND_W-1:0]      lock_kind;
    logic                   garbage_valid;
    logic                   garbage_ready;
    logic [COLS-1:0]        garbage_row;

    modport master (
        output lock_valid, lock_mask, lock_kind, garbage_valid, garbage_row,
        input  lock_ready, garbage_ready
    );

    modport slave (
        input  lock_valid, lock_mask, lock_kind, garbage_valid, garbage_row,
        output lock_ready, garbage_ready
    );
endinterface

// File: rtl/tetris_garbage_fifo.sv
// Queue of pending garbage rows; push handshake, pop strobe, head peek.
module tetris_garbage_fifo #(
    parameter int COLS  = 10,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear,
    input  logic            push_valid,
    output logic            push_ready,
    input  logic [COLS-1:0] push_data,
    input  logic            pop,
    output logic [COLS-1:0] head,
    output logic [CW-1:0]   count
);
    logic [DEPTH-1:0][COLS-1:0] mem;
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic                       push, do_pop;

    assign push_ready = (count != CW'(DEPTH));
    assign push       = push_valid && push_ready;
    assign do_pop     = pop && (count != '0);
    assign head       = mem[rd_ptr];

    // Row storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/tetris_field.sv
// Playfield store: lock pieces, clear full rows, raise queued garbage from the bottom.
module tetris_field
    import tetris_pkg::*;
#(
    parameter int COLS          = 10,
    parameter int ROWS          = 20,
    parameter int KIND_W        = 4,
    parameter int GARBAGE_DEPTH = 8,
    parameter int GARBAGE_KIND  = KIND_GARBAGE,
    localparam int PW           = $clog2(GARBAGE_DEPTH + 1),
    localparam int LW           = $clog2(ROWS + 1),
    localparam int RW           = $clog2(ROWS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear_i,
    tetris_field_if.slave        bus,
    output logic [COLS*ROWS-1:0] occ,
    input  logic [4:0]           rd_x,
    input  logic [4:0]           rd_y,
    output logic [KIND_W-1:0]    rd_kind,
    output logic                 busy,
    output logic [PW-1:0]        pending,
    output logic                 done,
    output logic [LW-1:0]        lines_cleared,
    output logic                 topout
);
    field_state_t state, state_nxt;

    logic [ROWS-1:0][COLS-1:0][KIND_W-1:0] cells;
    logic [ROWS-1:0]      row_full;
    logic [COLS*ROWS-1:0] mask_q;
    logic [KIND_W-1:0]    kind_q;
    logic [RW-1:0]        r;
    logic [LW-1:0]        counter;

    logic                 fifo_push_valid, fifo_ready, fifo_pop;
    logic [COLS-1:0]      fifo_head;
    logic [PW-1:0]        fifo_count;

    tetris_garbage_fifo #(.COLS(COLS), .DEPTH(GARBAGE_DEPTH)) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear_i),
        .push_valid (fifo_push_valid),
        .push_ready (fifo_ready),
        .push_data  (bus.garbage_row),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .count      (fifo_count)
    );

    assign pending = fifo_count;

    // Occupancy and per-row fullness straight from the cell registers.
    always_comb begin
        occ      = '0;
        row_full = '0;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++)
                occ[y*COLS+x] = (cells[y][x] != KIND_W'(KIND_EMPTY));
            row_full[y] = &occ[y*COLS +: COLS];
        end
    end

    // State register; clear_i abandons any sequence without a done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     state <= F_IDLE;
        else if (clear_i) state <= F_IDLE;
        else              state <= state_nxt;
    end

    // Next-state: SCAN walks bottom-up, revisiting a row after each SHIFT.
    always_comb begin
        state_nxt = state;
        case (state)
            F_IDLE:  if (bus.lock_valid && bus.lock_ready) state_nxt = F_LOCK;
            F_LOCK:  state_nxt = F_SCAN;
            F_SCAN:  if (row_full[r])  state_nxt = F_SHIFT;
                     else if (r == '0) state_nxt = F_RISE;
            F_SHIFT: state_nxt = F_SCAN;
            F_RISE:  if (fifo_count == '0) state_nxt = F_DONE;
            F_DONE:  state_nxt = F_IDLE;
            default: state_nxt = F_IDLE;
        endcase
    end

    // Handshake and status outputs; garbage pushes stall only while rows rise.
    always_comb begin
        busy              = (state != F_IDLE);
        done              = (state == F_DONE);
        bus.lock_ready    = (state == F_IDLE) && !topout;
        bus.garbage_ready = fifo_ready && (state != F_RISE);
        fifo_push_valid   = bus.garbage_valid && (state != F_RISE) && (|bus.garbage_row);
        fifo_pop          = (state == F_RISE) && (fifo_count != '0);
    end

    // Field datapath: capture, lock, row clear shifts and garbage rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cells         <= '0;
            mask_q        <= '0;
            kind_q        <= '0;
            r             <= '0;
            counter       <= '0;
            lines_cleared <= '0;
            topout        <= 1'b0;
        end else if (clear_i) begin
            cells         <= '0;
            mask_q        <= '0;
            kind_q        <= '0;
            r             <= '0;
            counter       <= '0;
            lines_cleared <= '0;
            topout        <= 1'b0;
        end else begin
            case (state)
                F_IDLE: begin
                    if (bus.lock_valid && bus.lock_ready) begin
                        mask_q <= bus.lock_mask;
                        kind_q <= bus.lock_kind;
                    end
                end
                F_LOCK: begin
                    for (int y = 0; y < ROWS; y++)
                        for (int x = 0; x < COLS; x++)
                            if (mask_q[y*COLS+x]) cells[y][x] <= kind_q;
                    // Overlap or an empty piece means spawn failed: game over.
                    if (((mask_q & occ) != '0) || (mask_q == '0)) topout <= 1'b1;
                    r       <= RW'(ROWS - 1);
                    counter <= '0;
                end
                F_SCAN: begin
                    if (!row_full[r] && (r != '0)) r <= r - RW'(1);
                end
                F_SHIFT: begin
                    for (int y = 1; y < ROWS; y++)
                        if (RW'(y) <= r) cells[y] <= cells[y-1];
                    cells[0] <= '0;
                    counter  <= counter + LW'(1);
                end
                F_RISE: begin
                    if (fifo_count != '0) begin
                        // Anything in the top row gets pushed off the board.
                        if (|occ[COLS-1:0]) topout <= 1'b1;
                        for (int y = 0; y < ROWS - 1; y++)
                            cells[y] <= cells[y+1];
                        for (int x = 0; x < COLS; x++)
                            cells[ROWS-1][x] <= fifo_head[x] ? KIND_W'(GARBAGE_KIND) : '0;
                    end else begin
                        // Loaded on entry to DONE so it is valid alongside the pulse.
                        lines_cleared <= counter;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered render read; out-of-range coordinates match no cell and read 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_kind <= '0;
        end else if (clear_i) begin
            rd_kind <= '0;
        end else begin
            rd_kind <= '0;
            for (int y = 0; y < ROWS; y++)
                for (int x = 0; x < COLS; x++)
                    if ((rd_y == 5'(y)) && (rd_x == 5'(x))) rd_kind <= cells[y][x];
        end
    end
endmodule

// File: tb/tb_tetris_field.sv
// Scoreboard bench for tetris_field: a behavioural board model predicts each lock sequence.
module tb_tetris_field;

    localparam int COLS  = 10;
    localparam int ROWS  = 20;
    localparam int KW    = 4;
    localparam int DEPTH = 8;
    localparam int GK    = 8;
    localparam int N     = COLS * ROWS;

    logic           clk     = 1'b0;
    logic           reset_n = 1'b0;
    logic           clear_i = 1'b0;
    logic [N-1:0]   occ;
    logic [4:0]     rd_x = '0;
    logic [4:0]     rd_y = '0;
    logic [KW-1:0]  rd_kind;
    logic           busy, done, topout;
    logic [3:0]     pending;
    logic [4:0]     lines_cleared;

    tetris_field_if #(.COLS(COLS), .ROWS(ROWS), .KIND_W(KW)) bus ();

    tetris_field #(
        .COLS(COLS), .ROWS(ROWS), .KIND_W(KW), .GARBAGE_DEPTH(DEPTH), .GARBAGE_KIND(GK)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear_i       (clear_i),
        .bus           (bus),
        .occ           (occ),
        .rd_x          (rd_x),
        .rd_y          (rd_y),
        .rd_kind       (rd_kind),
        .busy          (busy),
        .pending       (pending),
        .done          (done),
        .lines_cleared (lines_cleared),
        .topout        (topout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   lines;
        int   lat;
        logic top;
    } exp_t;

    exp_t            sb[$];
    int              mdl[ROWS][COLS];
    logic [COLS-1:0] mq[$];
    logic            mtop;
    int              checks = 0;
    int              errors = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] model_occ();
        logic [N-1:0] o = '0;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                o[y*COLS+x] = (mdl[y][x] != 0);
        return o;
    endfunction

    task automatic model_reset();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                mdl[y][x] = 0;
        mq.delete();
        mtop = 1'b0;
    endtask

    // Handshake one lock, then predict the whole sequence and queue the expectation.
    task automatic start_lock(input logic [N-1:0] mask, input int kind);
        int              w = 0;
        int              k = 0;
        int              g;
        int              d;
        bit              full;
        exp_t            e;
        logic [N-1:0]    o;
        logic [COLS-1:0] row;
        int              nf[ROWS][COLS];
        while (!bus.lock_ready && w < 100) begin
            step();
            w++;
        end
        chk("lock_ready_wait", bus.lock_ready, 1);
        if (!bus.lock_ready) return;
        bus.lock_valid = 1'b1;
        bus.lock_mask  = mask;
        bus.lock_kind  = kind[KW-1:0];
        step();
        bus.lock_valid = 1'b0;
        o = model_occ();
        if (mask == '0 || (mask & o) != '0) mtop = 1'b1;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                if (mask[y*COLS+x]) mdl[y][x] = kind;
        // Full rows vanish; the survivors settle to the bottom in order.
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                nf[y][x] = 0;
        d = ROWS - 1;
        for (int y = ROWS - 1; y >= 0; y--) begin
            full = 1'b1;
            for (int x = 0; x < COLS; x++)
                if (mdl[y][x] == 0) full = 1'b0;
            if (full) k++;
            else begin
                for (int x = 0; x < COLS; x++) nf[d][x] = mdl[y][x];
                d--;
            end
        end
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                mdl[y][x] = nf[y][x];
        g = mq.size();
        while (mq.size() > 0) begin
            row = mq.pop_front();
            for (int x = 0; x < COLS; x++)
                if (mdl[0][x] != 0) mtop = 1'b1;
            for (int y = 0; y < ROWS - 1; y++)
                for (int x = 0; x < COLS; x++)
                    mdl[y][x] = mdl[y+1][x];
            for (int x = 0; x < COLS; x++)
                mdl[ROWS-1][x] = row[x] ? GK : 0;
        end
        // Handshake edge to DONE: LOCK, ROWS scans, 2 per cleared row, one RISE per row plus exit.
        e.lines = k;
        e.lat   = ROWS + 2 * k + 2 + g;
        e.top   = mtop;
        sb.push_back(e);
    endtask

    task automatic sweep();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                rd_x = 5'(x);
                rd_y = 5'(y);
                step();
                chk($sformatf("rd_kind(%0d,%0d)", x, y), rd_kind, mdl[y][x]);
            end
        rd_x = 5'(COLS); rd_y = 5'(ROWS - 1);
        step();
        chk("rd_x_out_of_range", rd_kind, 0);
        rd_x = 5'd0; rd_y = 5'(ROWS);
        step();
        chk("rd_y_out_of_range", rd_kind, 0);
    endtask

    // Pop the expectation when done appears; a lock_valid pulse mid-sequence must be ignored.
    task automatic wait_done(input bit do_sweep);
        exp_t e;
        int   lat = 0;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        while (!done && lat < 400) begin
            step();
            lat++;
            if (lat == 2) bus.lock_valid = 1'b1;
            if (lat == 3) begin
                chk("busy_mid", busy, 1);
                chk("lock_ready_mid", bus.lock_ready, 0);
            end
            if (lat == 6) bus.lock_valid = 1'b0;
        end
        bus.lock_valid = 1'b0;
        chk("done_seen", done, 1);
        chk("latency", lat, e.lat);
        chk("lines_cleared", lines_cleared, e.lines);
        step();
        chk("done_pulse_end", done, 0);
        chk("busy_after", busy, 0);
        chk("lines_held", lines_cleared, e.lines);
        chk("topout", topout, e.top);
        chk("pending_drained", pending, mq.size());
        chk("occ", occ, model_occ());
        if (do_sweep) sweep();
    endtask

    task automatic push_garbage(input logic [COLS-1:0] row, input int hold);
        logic er;
        er = (mq.size() < DEPTH);
        chk("garbage_ready", bus.garbage_ready, er);
        bus.garbage_valid = 1'b1;
        bus.garbage_row   = row;
        repeat (hold) step();
        bus.garbage_valid = 1'b0;
        if (er && row != '0) mq.push_back(row);
        chk("pending", pending, mq.size());
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        model_reset();
        chk("clr_occ", occ, 0);
        chk("clr_pending", pending, 0);
        chk("clr_topout", topout, 0);
        chk("clr_busy", busy, 0);
        chk("clr_lines", lines_cleared, 0);
        chk("clr_lock_ready", bus.lock_ready, 1);
        chk("clr_garbage_ready", bus.garbage_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N-1:0]    m;
        logic [COLS-1:0] gr;
        bus.lock_valid    = 1'b0;
        bus.lock_mask     = '0;
        bus.lock_kind     = '0;
        bus.garbage_valid = 1'b0;
        bus.garbage_row   = '0;
        model_reset();
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lines", lines_cleared, 0);
        chk("rst_topout", topout, 0);
        chk("rst_pending", pending, 0);
        chk("rst_rd_kind", rd_kind, 0);
        chk("rst_occ", occ, 0);
        chk("rst_lock_ready", bus.lock_ready, 1);
        chk("rst_garbage_ready", bus.garbage_ready, 1);

        // Horizontal I on the bottom row of an empty board
        m = '0;
        m[19*COLS +: 4] = '1;
        start_lock(m, 1);
        wait_done(1);

        // Two nearly full rows completed by a vertical I in column 9
        do_clear();
        m = '0;
        m[18*COLS +: 9] = '1;
        m[19*COLS +: 9] = '1;
        start_lock(m, 2);
        wait_done(0);
        m = '0;
        for (int y = 16; y < 20; y++) m[y*COLS+9] = 1'b1;
        start_lock(m, 3);
        wait_done(1);

        // Three garbage rows raised under an O piece at the top
        do_clear();
        repeat (3) push_garbage(10'b1111111110, 1);
        m = '0;
        m[0*COLS+4 +: 2] = '1;
        m[1*COLS+4 +: 2] = '1;
        start_lock(m, 4);
        wait_done(1);

        // FIFO fill to depth, zero row dropped, overflow refused, FIFO order on drain
        do_clear();
        repeat (7) begin
            gr = COLS'($urandom_range(1, (1 << COLS) - 1));
            push_garbage(gr, 1);
        end
        push_garbage('0, 1);
        push_garbage(10'b1010101010, 1);
        push_garbage(10'b0101010101, 3);
        chk("pending_full", pending, DEPTH);
        m = '0;
        m[19*COLS] = 1'b1;
        start_lock(m, 5);
        wait_done(1);

        // Top-out from a rising row 0, then garbage still queues and locks are refused
        do_clear();
        m = '0;
        m[0] = 1'b1;
        start_lock(m, 6);
        wait_done(0);
        push_garbage(10'b0000011111, 1);
        m = '0;
        m[19*COLS+5] = 1'b1;
        start_lock(m, 7);
        wait_done(0);
        chk("topout_lock_ready", bus.lock_ready, 0);
        push_garbage(10'b1100000011, 1);
        bus.lock_valid = 1'b1;
        repeat (3) begin
            step();
            chk("topout_no_lock", busy, 0);
        end
        bus.lock_valid = 1'b0;
        do_clear();

        // Empty mask is a top-out too
        start_lock('0, 1);
        wait_done(0);
        do_clear();

        // Asynchronous reset in the middle of the row scan
        m = '0;
        m[19*COLS +: 4] = '1;
        start_lock(m, 1);
        repeat (6) step();
        reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_occ", occ, 0);
        chk("arst_done", done, 0);
        chk("arst_pending", pending, 0);
        sb.delete();
        model_reset();
        repeat (2) step();
        reset_n = 1'b1;
        repeat (4) begin
            step();
            chk("arst_no_done", done, 0);
        end
        m = '0;
        m[10*COLS+3 +: 3] = '1;
        start_lock(m, 9);
        wait_done(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
